// File: rtl/rvga_types.sv
// Shared types for the rvga multiply/divide execute slice: M-extension
// operation encodings, FSM states and operand-class helpers.
package rvga_types;

   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } md_state_e;

   function automatic logic op_is_div(input md_op_e op);
      return op[2];
   endfunction

   function automatic logic op_a_signed(input md_op_e op);
      return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
   endfunction

   function automatic logic op_b_signed(input md_op_e op);
      return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
   endfunction

endpackage

// File: rtl/rvga_md_iter.sv
// Bit-serial unsigned datapath: shift-add multiply or restoring divide on
// operand magnitudes, one bit per step, with its own step counter.
module rvga_md_iter #(
   parameter int width_p = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               load_i,
   input  logic               step_i,
   input  logic               is_div_i,
   input  logic [width_p-1:0] a_i,
   input  logic [width_p-1:0] b_i,
   output logic               last_o,
   output logic [width_p-1:0] hi_nxt_o,
   output logic [width_p-1:0] lo_nxt_o
);

   localparam int cnt_w = $clog2(width_p + 1);

   logic [width_p-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
   logic [cnt_w-1:0]   cnt_q, cnt_d;
   logic               is_div_q, is_div_d;

   logic [width_p:0]   sum, rs;
   logic [width_p-1:0] diff, hi_step, lo_step;
   logic               ge;

   // hi holds the product high half / partial remainder, lo the multiplier / quotient
   always_comb begin
      sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      rs   = {hi_q, lo_q[width_p-1]};
      ge   = (rs >= {1'b0, b_q});
      diff = rs[width_p-1:0] - b_q;
      if (is_div_q) begin
         hi_step = ge ? diff : rs[width_p-1:0];
         lo_step = {lo_q[width_p-2:0], ge};
      end else begin
         hi_step = sum[width_p:1];
         lo_step = {sum[0], lo_q[width_p-1:1]};
      end
   end

   always_comb begin
      hi_d     = hi_q;
      lo_d     = lo_q;
      b_d      = b_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      if (load_i) begin
         hi_d     = '0;
         lo_d     = a_i;
         b_d      = b_i;
         cnt_d    = '0;
         is_div_d = is_div_i;
      end else if (step_i) begin
         hi_d  = hi_step;
         lo_d  = lo_step;
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hi_q     <= '0;
         lo_q     <= '0;
         b_q      <= '0;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
      end else begin
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         b_q      <= b_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
      end
   end

   assign last_o   = (cnt_q == cnt_w'(width_p - 1));
   assign hi_nxt_o = hi_step;
   assign lo_nxt_o = lo_step;

endmodule

// File: rtl/rvga_md_execute.sv
// RV M-extension execute unit: input registers, operand forwarding, and an
// IDLE/CALC/DONE sequencer around the bit-serial multiply/divide datapath.
module rvga_md_execute
   import rvga_types::*;
#(
   parameter int width_p   = 32,
   parameter int fwd_els_p = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         stall_v_i,
   input  logic                         flush_i,
   input  logic                         op_v_i,
   input  logic [2:0]                   funct3_i,
   input  logic [width_p-1:0]           rs1_data_i,
   input  logic [width_p-1:0]           rs2_data_i,
   input  logic [fwd_els_p-1:0]         rs1_fwd_v_i,
   input  logic [fwd_els_p-1:0]         rs2_fwd_v_i,
   input  logic [fwd_els_p*width_p-1:0] fwd_data_i,
   output logic                         busy_o,
   output logic                         result_v_o,
   output logic [width_p-1:0]           result_o
);

   logic                op_v_q, op_v_d;
   logic [2:0]          funct3_q, funct3_d;
   logic [width_p-1:0]  rs1_q, rs1_d, rs2_q, rs2_d;
   md_state_e           state_q, state_d;
   md_op_e              op_q, op_d;
   logic                sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
   logic                result_v_q, result_v_d;
   logic [width_p-1:0]  result_q, result_d;

   md_op_e              cur_op;
   logic [width_p-1:0]  opa, opb, mag_a, mag_b;
   logic                sa_now, sb_now;
   logic                iter_load, iter_step, iter_last;
   logic [width_p-1:0]  iter_hi, iter_lo;

   // Signs were stripped before iterating; restore them here. A zero divisor
   // keeps the raw all-ones quotient, and the remainder carries the dividend sign.
   function automatic logic [width_p-1:0] md_result(input md_op_e op, input logic sa,
                                                   input logic sb, input logic dz,
                                                   input logic [width_p-1:0] hi,
                                                   input logic [width_p-1:0] lo);
      logic [2*width_p-1:0] prod;
      logic [width_p-1:0]   res;
      prod = (sa ^ sb) ? -{hi, lo} : {hi, lo};
      case (op)
         MD_MUL:                       res = prod[width_p-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: res = prod[2*width_p-1:width_p];
         MD_DIV, MD_DIVU:              res = dz ? '1 : ((sa ^ sb) ? -lo : lo);
         default:                      res = sa ? -hi : hi;
      endcase
      return res;
   endfunction

   always_comb begin
      op_v_d   = flush_i ? 1'b0 : (stall_v_i ? op_v_q : op_v_i);
      funct3_d = stall_v_i ? funct3_q : funct3_i;
      rs1_d    = stall_v_i ? rs1_q : rs1_data_i;
      rs2_d    = stall_v_i ? rs2_q : rs2_data_i;
   end

   // Lowest-numbered asserted forward source wins, so scan from the top down.
   always_comb begin
      opa = rs1_q;
      opb = rs2_q;
      for (int k = fwd_els_p - 1; k >= 0; k--) begin
         if (rs1_fwd_v_i[k]) opa = fwd_data_i[k*width_p +: width_p];
         if (rs2_fwd_v_i[k]) opb = fwd_data_i[k*width_p +: width_p];
      end
   end

   always_comb begin
      cur_op = md_op_e'(funct3_q);
      sa_now = op_a_signed(cur_op) & opa[width_p-1];
      sb_now = op_b_signed(cur_op) & opb[width_p-1];
      mag_a  = sa_now ? -opa : opa;
      mag_b  = sb_now ? -opb : opb;
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      sa_d      = sa_q;
      sb_d      = sb_q;
      dz_d      = dz_q;
      result_d  = result_q;
      iter_load = 1'b0;
      iter_step = 1'b0;
      if (flush_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (op_v_q) begin
                  state_d   = ST_CALC;
                  iter_load = 1'b1;
                  op_d      = cur_op;
                  sa_d      = sa_now;
                  sb_d      = sb_now;
                  dz_d      = (opb == '0);
               end
            end
            ST_CALC: begin
               iter_step = 1'b1;
               if (iter_last) begin
                  state_d  = ST_DONE;
                  result_d = md_result(op_q, sa_q, sb_q, dz_q, iter_hi, iter_lo);
               end
            end
            ST_DONE: begin
               if (!stall_v_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
      result_v_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         op_v_q     <= 1'b0;
         funct3_q   <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         state_q    <= ST_IDLE;
         op_q       <= MD_MUL;
         sa_q       <= 1'b0;
         sb_q       <= 1'b0;
         dz_q       <= 1'b0;
         result_v_q <= 1'b0;
         result_q   <= '0;
      end else begin
         op_v_q     <= op_v_d;
         funct3_q   <= funct3_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         state_q    <= state_d;
         op_q       <= op_d;
         sa_q       <= sa_d;
         sb_q       <= sb_d;
         dz_q       <= dz_d;
         result_v_q <= result_v_d;
         result_q   <= result_d;
      end
   end

   rvga_md_iter #(
      .width_p (width_p)
   ) u_iter (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load_i   (iter_load),
      .step_i   (iter_step),
      .is_div_i (op_is_div(cur_op)),
      .a_i      (mag_a),
      .b_i      (mag_b),
      .last_o   (iter_last),
      .hi_nxt_o (iter_hi),
      .lo_nxt_o (iter_lo)
   );

   assign busy_o     = (state_q == ST_CALC) || ((state_q == ST_IDLE) && op_v_q);
   assign result_v_o = result_v_q;
   assign result_o   = result_q;

endmodule

// File: tb/tb_rvga_md_execute.sv
// Bench for rvga_md_execute: directed corner ops plus random ops, checked each
// cycle against an arithmetic reference with a cycle-count timing model.
module tb_rvga_md_execute;

   localparam int W = 32;
   localparam int F = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         stall = 1'b0;
   logic         flush = 1'b0;
   logic         op_v = 1'b0;
   logic [2:0]   f3 = '0;
   logic [W-1:0] rs1 = '0, rs2 = '0;
   logic [F-1:0] fv1 = '0, fv2 = '0;
   logic [F*W-1:0] fdata = '0;
   logic         busy, rv;
   logic [W-1:0] res;

   int n_vec = 0;
   int n_err = 0;
   bit started = 1'b0;

   always #5 clk = ~clk;

   rvga_md_execute #(.width_p(W), .fwd_els_p(F)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .stall_v_i   (stall),
      .flush_i     (flush),
      .op_v_i      (op_v),
      .funct3_i    (f3),
      .rs1_data_i  (rs1),
      .rs2_data_i  (rs2),
      .rs1_fwd_v_i (fv1),
      .rs2_fwd_v_i (fv2),
      .fwd_data_i  (fdata),
      .busy_o      (busy),
      .result_v_o  (rv),
      .result_o    (res)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference arithmetic straight from the RISC-V M rules using 64-bit math.
   function automatic logic [W-1:0] ref_md(input logic [2:0] f, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      case (f)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return '1;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            p = sa / sb; return p[31:0];
         end
         3'd5: return (b == 0) ? '1 : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
            p = sa % sb; return p[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic logic [W-1:0] pick_opnd(input logic [F-1:0] v, input logic [F*W-1:0] fd,
                                              input logic [W-1:0] rsv);
      for (int k = 0; k < F; k++)
         if (v[k]) return fd[k*W +: W];
      return rsv;
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Timing model: phase 0 idle, 1 busy-counting, 2 result presented.
   logic         m_opv = 1'b0;
   logic [2:0]   m_f3 = '0;
   logic [W-1:0] m_rs1 = '0, m_rs2 = '0, m_pend = '0, m_res = '0;
   int           m_phase = 0;
   int           m_k = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_opv = 1'b0; m_f3 = '0; m_rs1 = '0; m_rs2 = '0;
         m_phase = 0; m_k = 0; m_pend = '0; m_res = '0;
      end else begin
         if (flush) m_phase = 0;
         else if (m_phase == 0) begin
            if (m_opv) begin
               m_pend  = ref_md(m_f3, pick_opnd(fv1, fdata, m_rs1), pick_opnd(fv2, fdata, m_rs2));
               m_phase = 1;
               m_k     = 1;
            end
         end else if (m_phase == 1) begin
            m_k++;
            if (m_k == W + 1) begin
               m_phase = 2;
               m_res   = m_pend;
            end
         end else if (!stall) m_phase = 0;
         if (flush) m_opv = 1'b0;
         else if (!stall) m_opv = op_v;
         if (!stall) begin
            m_f3 = f3; m_rs1 = rs1; m_rs2 = rs2;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("busy", busy, ((m_phase == 1) || (m_phase == 0 && m_opv)) ? 1 : 0);
         chk("result_v", rv, (m_phase == 2) ? 1 : 0);
         if (m_phase == 2) chk("result", res, m_res);
      end
   end

   task automatic run_op(input string nm, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [F-1:0] v1, input logic [F-1:0] v2,
                         input logic [F*W-1:0] fd, input int hold, input bit lit_en,
                         input logic [W-1:0] lit);
      int busy_n;
      bit got;
      logic [W-1:0] cap;
      busy_n = 0; got = 1'b0; cap = '0;
      op_v = 1'b1; f3 = op; rs1 = a; rs2 = b;
      @(posedge clk); #1;
      op_v = 1'b0; fv1 = v1; fv2 = v2; fdata = fd;
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge clk);
         if (busy) busy_n++;
         if (rv) begin got = 1'b1; cap = res; end
      end
      if (!got) begin
         n_vec++; n_err++;
         $display("FAIL %s timeout: no result_v after 200 cycles, expected one", nm);
      end else begin
         if (lit_en) chk(nm, cap, lit);
         chk("busy_cycles", busy_n, W + 1);
         if (hold > 0) begin
            stall = 1'b1;
            for (int h = 0; h < hold; h++) begin
               @(negedge clk);
               chk("done_hold_v", rv, 1);
               chk("done_hold_res", res, cap);
            end
            stall = 1'b0;
            @(negedge clk);
            chk("idle_after_release", rv, 0);
         end else begin
            @(negedge clk);
            chk("rv_one_cycle", rv, 0);
         end
      end
      @(posedge clk); #1;
      fv1 = '0; fv2 = '0;
   endtask

   initial begin
      #1000000;
      n_vec++; n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      bit seen;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      started = 1'b1;
      chk("rst_busy", busy, 0);
      chk("rst_rv", rv, 0);
      chk("rst_res", res, 0);
      rst = 1'b0;

      run_op("mul_7xm3", 3'd0, 32'd7, 32'hFFFF_FFFD, '0, '0, '0, 0, 1'b1, 32'hFFFF_FFEB);
      run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, '0, '0, 0, 1'b1, 32'hFFFF_FFFE);
      run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, '0, '0, '0, 0, 1'b1, 32'h4000_0000);
      run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, '0, '0, '0, 0, 1'b1, 32'h8000_0000);
      run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, '0, '0, '0, 0, 1'b1, 32'h0);
      run_op("divu_by0", 3'd5, 32'd5, 32'd0, '0, '0, '0, 0, 1'b1, 32'hFFFF_FFFF);
      run_op("remu_by0", 3'd7, 32'd5, 32'd0, '0, '0, '0, 0, 1'b1, 32'd5);
      run_op("rem_fwd", 3'd6, 32'd0, 32'd0, 2'b10, 2'b01, {32'hFFFF_FFF9, 32'd2}, 0, 1'b1,
             32'hFFFF_FFFF);
      run_op("div_stall", 3'd4, 32'd100, 32'hFFFF_FFF9, '0, '0, '0, 3, 1'b1, 32'hFFFF_FFF2);

      // flush in the middle of CALC
      op_v = 1'b1; f3 = 3'd0; rs1 = 32'd123; rs2 = 32'd456;
      @(posedge clk); #1; op_v = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      chk("flush_busy", busy, 0);
      seen = 1'b0;
      for (int c = 0; c < W + 5; c++) begin
         @(negedge clk);
         if (rv) seen = 1'b1;
      end
      chk("flush_no_rv", seen, 0);
      @(posedge clk); #1;

      // asynchronous reset in the middle of CALC
      op_v = 1'b1; f3 = 3'd5; rs1 = 32'd999; rs2 = 32'd3;
      @(posedge clk); #1; op_v = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_rv", rv, 0);
      chk("rst_mid_res", res, 0);
      @(posedge clk); #1; rst = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < W + 5; c++) begin
         @(negedge clk);
         if (rv) seen = 1'b1;
      end
      chk("rst_no_rv", seen, 0);
      @(posedge clk); #1;
      run_op("divu_after_rst", 3'd5, 32'd100, 32'd7, '0, '0, '0, 0, 1'b1, 32'd14);

      for (int i = 0; i < 40; i++) begin
         run_op("rand", 3'($urandom_range(0, 7)), pick(), pick(), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), {pick(), pick()}, $urandom_range(0, 2), 1'b0, '0);
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            @(posedge clk); #1;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
